// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch slice.
package instr_fetch_pkg;

    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned INSTR_WIDTH = 32;

    // Byte distance between consecutive instruction words
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    // One prefetched instruction together with the byte address it came from
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with push, pop and flush.
// Pops on an empty FIFO and pushes into a full FIFO without a pop are ignored.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // Qualify requests against current occupancy
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count < CW'(DEPTH)) || pop_ok);
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues reads on the shared instruction bus,
// buffers returned words in a prefetch FIFO and hands them to decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned           FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic                   re_o,
    output logic                   we_o,
    input  logic [INSTR_WIDTH-1:0] bus_i,
    input  logic                   bus_gnt_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         count;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;
    logic                  pop;
    logic                  fifo_pop;

    assign addr_o        = pc;
    assign we_o          = 1'b0;
    assign instr_valid_o = (count != '0);
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

    // Issue a read when granted and the FIFO has room (or frees a slot now);
    // a redirect discards any pop, since the whole FIFO is flushed anyway
    always_comb begin
        pop        = instr_valid_o && instr_ready_i;
        re_o       = !rst && !redirect_i && bus_gnt_i &&
                     ((count < CW'(FIFO_DEPTH)) || pop);
        fifo_pop   = pop && !redirect_i;
        push_entry = '{instr: bus_i, pc: pc};
    end

    // PC: reset > redirect (word-aligned target) > advance on each issued read
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_i) begin
            pc <= redirect_pc_i & ~ADDR_WIDTH'(3);
        end else if (re_o) begin
            pc <= pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_i),
        .push       (re_o),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// stimulus, all compared against a queue-based reference model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int unsigned           DEPTH = 2;
    localparam logic [ADDR_WIDTH-1:0] RPC   = '0;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [ADDR_WIDTH-1:0]  addr_o;
    logic                   re_o;
    logic                   we_o;
    logic [INSTR_WIDTH-1:0] bus_i;
    logic                   bus_gnt_i;
    logic                   redirect_i;
    logic [ADDR_WIDTH-1:0]  redirect_pc_i;
    logic                   instr_valid_o;
    logic                   instr_ready_i;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0]  instr_pc_o;

    typedef struct {
        logic [31:0]           w;
        logic [ADDR_WIDTH-1:0] pc;
    } ent_t;

    ent_t                  q[$];
    logic [ADDR_WIDTH-1:0] model_pc;
    bit                    model_init = 1'b0;
    int                    errors = 0;
    int                    checks = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr_o        (addr_o),
        .re_o          (re_o),
        .we_o          (we_o),
        .bus_i         (bus_i),
        .bus_gnt_i     (bus_gnt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    function automatic logic [31:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Zero-latency memory: word for the current address appears immediately
    assign bus_i = mem_word(addr_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model, then advance one clock and update it
    task automatic step();
        bit pop;
        bit exp_re;
        #1;
        pop    = (q.size() != 0) && (instr_ready_i === 1'b1);
        exp_re = (rst === 1'b0) && (redirect_i === 1'b0) && (bus_gnt_i === 1'b1) &&
                 ((q.size() < DEPTH) || pop);
        chk("re_o", re_o, exp_re);
        chk("we_o", we_o, 0);
        if (model_init) begin
            chk("addr_o", addr_o, model_pc);
            chk("valid", instr_valid_o, q.size() != 0);
            if (q.size() != 0) begin
                chk("instr", instr_o, q[0].w);
                chk("instr_pc", instr_pc_o, q[0].pc);
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            model_pc   = RPC;
            model_init = 1'b1;
        end else if (redirect_i) begin
            q.delete();
            model_pc = ADDR_WIDTH'(int'(redirect_pc_i) - (int'(redirect_pc_i) % 4));
        end else begin
            if (pop) void'(q.pop_front());
            if (exp_re) begin
                q.push_back('{w: mem_word(model_pc), pc: model_pc});
                model_pc = ADDR_WIDTH'((int'(model_pc) + 4) % (1 << ADDR_WIDTH));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus_gnt_i     = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b1;
        @(negedge clk);

        // Reset held for two cycles
        step();
        #1 chk("rst_re", re_o, 0);
        step();
        #1 chk("rst_valid", instr_valid_o, 0);

        // Release and stream A, B, C
        rst = 1'b0;
        #1 chk("first_re", re_o, 1);
        chk("first_addr", addr_o, 0);
        step();
        #1 chk("stream_pc0", instr_pc_o, 0);
        chk("stream_w0", instr_o, mem_word(0));
        step();
        #1 chk("stream_pc4", instr_pc_o, 4);
        step();
        #1 chk("stream_pc8", instr_pc_o, 8);
        chk("stream_w8", instr_o, mem_word(8));
        step();

        // Backpressure from a fresh reset
        rst = 1'b1;
        step();
        rst           = 1'b0;
        instr_ready_i = 1'b0;
        step();
        step();
        #1 chk("bp_re", re_o, 0);
        chk("bp_addr", addr_o, 8);
        chk("bp_head", instr_o, mem_word(0));
        step();
        #1 chk("bp_stable", instr_o, mem_word(0));
        chk("bp_stable_pc", instr_pc_o, 0);
        instr_ready_i = 1'b1;
        #1 chk("bp_full_pop_re", re_o, 1);
        chk("bp_full_pop_addr", addr_o, 8);
        step();
        instr_ready_i = 1'b0;
        #1 chk("bp_after_pop_pc", instr_pc_o, 4);
        chk("bp_after_pop_valid", instr_valid_o, 1);
        step();

        // Redirect to an unaligned target while streaming
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0042;
        #1 chk("redir_re", re_o, 0);
        step();
        redirect_i = 1'b0;
        #1 chk("redir_valid", instr_valid_o, 0);
        chk("redir_addr", addr_o, 16'h0040);
        step();
        #1 chk("redir_first_pc", instr_pc_o, 16'h0040);
        chk("redir_first_w", instr_o, mem_word(16'h0040));
        step();

        // Grant loss with two entries buffered
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0100;
        instr_ready_i = 1'b0;
        step();
        redirect_i = 1'b0;
        step();
        step();
        bus_gnt_i     = 1'b0;
        instr_ready_i = 1'b1;
        #1 chk("gnt_re0", re_o, 0);
        chk("gnt_pc0", instr_pc_o, 16'h0100);
        step();
        #1 chk("gnt_re1", re_o, 0);
        chk("gnt_pc1", instr_pc_o, 16'h0104);
        step();
        #1 chk("gnt_empty", instr_valid_o, 0);
        chk("gnt_addr_frozen", addr_o, 16'h0108);
        step();

        // PC wrap, then reset with the FIFO full
        bus_gnt_i     = 1'b1;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'hFFFC;
        step();
        redirect_i = 1'b0;
        #1 chk("wrap_addr_top", addr_o, 16'hFFFC);
        step();
        #1 chk("wrap_addr_zero", addr_o, 0);
        step();
        #1 chk("wrap_head_pc", instr_pc_o, 16'hFFFC);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rst_full_valid", instr_valid_o, 0);
        chk("rst_full_addr", addr_o, RPC);
        step();

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            redirect_i    = ($urandom_range(0, 9) == 0);
            bus_gnt_i     = ($urandom_range(0, 3) != 0);
            instr_ready_i = ($urandom_range(0, 1) == 1);
            redirect_pc_i = ADDR_WIDTH'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
